// File: rtl/lorenz_frame_tx.sv
// Decimates lorenz (x, y, z) samples, queues the kept triples and streams each one
// as a framed byte sequence: sync 0xA5, payload MSB first, then an XOR checksum.
module lorenz_frame_tx #(
  parameter int Width  = 32,
  parameter int Depth  = 4,
  parameter int DecimW = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              sample_i,
  input  logic [Width-1:0]  xn_i,
  input  logic [Width-1:0]  yn_i,
  input  logic [Width-1:0]  zn_i,
  input  logic [DecimW-1:0] decim_i,
  input  logic              clr_ovf_i,
  output logic [7:0]        data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int TripleW  = 3 * Width;
  localparam int PayBytes = TripleW / 8;
  localparam int AW       = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW     = $clog2(PayBytes + 1);
  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CHECK} state_t;

  state_t              state_reg, state_next;
  logic [DecimW-1:0]   dec_cnt_reg;
  logic [TripleW-1:0]  mem [Depth];
  logic [TripleW-1:0]  rd_data_reg;
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]         count_reg, count_next;
  logic                avail_reg;
  logic [TripleW-1:0]  shreg_reg;
  logic [7:0]          csum_reg;
  logic [CntW-1:0]     byte_cnt_reg;
  logic                busy_reg, ovf_reg;
  logic                keep, full, push, pop, drop;

  assign keep = enable_i & sample_i & (dec_cnt_reg == '0);
  assign full = (count_reg == (AW+1)'(Depth));
  assign push = keep & (~full | pop);
  assign drop = keep & full & ~pop;

  assign valid_o    = (state_reg != IDLE);
  assign busy_o     = busy_reg;
  assign overflow_o = ovf_reg;

  always_comb begin
    data_o = 8'h00;
    case (state_reg)
      SYNC:    data_o = SyncByte;
      PAYLOAD: data_o = shreg_reg[TripleW-1 -: 8];
      CHECK:   data_o = csum_reg;
      default: data_o = 8'h00;
    endcase
  end

  // avail_reg lags the count by one cycle so the registered read has caught up
  // with a triple written into an empty FIFO before IDLE pops it.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (avail_reg && (count_reg != '0)) begin
          pop        = 1'b1;
          state_next = SYNC;
        end
      end
      SYNC:    if (ready_i) state_next = PAYLOAD;
      PAYLOAD: if (ready_i && (byte_cnt_reg == CntW'(PayBytes - 1))) state_next = CHECK;
      CHECK:   if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= {xn_i, yn_i, zn_i};
    rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      dec_cnt_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      avail_reg    <= 1'b0;
      shreg_reg    <= '0;
      csum_reg     <= 8'h00;
      byte_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (!enable_i)
        dec_cnt_reg <= '0;
      else if (sample_i)
        dec_cnt_reg <= (dec_cnt_reg >= decim_i) ? '0 : dec_cnt_reg + DecimW'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      avail_reg <= (count_reg != '0);
      busy_reg  <= (state_next != IDLE) | (count_next != '0);
      // a drop on the same edge as a clear leaves the flag set
      if (drop)
        ovf_reg <= 1'b1;
      else if (clr_ovf_i)
        ovf_reg <= 1'b0;
      if (pop) begin
        shreg_reg    <= rd_data_reg;
        csum_reg     <= 8'h00;
        byte_cnt_reg <= '0;
      end else if ((state_reg == PAYLOAD) && ready_i) begin
        csum_reg     <= csum_reg ^ shreg_reg[TripleW-1 -: 8];
        shreg_reg    <= {shreg_reg[TripleW-9:0], 8'h00};
        byte_cnt_reg <= byte_cnt_reg + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lorenz_frame_tx.sv
// Directed bench for lorenz_frame_tx: table of single-frame vectors plus
// hand-written decimation, overflow, reset and enable sequences.
module tb_lorenz_frame_tx;
  localparam int W = 32, D = 4, DW = 16, FB = 14;

  logic          clk_i = 1'b0;
  logic          rst_i, enable_i, sample_i, ready_i, clr_ovf_i;
  logic [W-1:0]  xn_i, yn_i, zn_i;
  logic [DW-1:0] decim_i;
  logic [7:0]    data_o;
  logic          valid_o, busy_o, overflow_o;

  always #5 clk_i = ~clk_i;

  lorenz_frame_tx #(.Width(W), .Depth(D), .DecimW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .sample_i(sample_i),
    .xn_i(xn_i), .yn_i(yn_i), .zn_i(zn_i), .decim_i(decim_i), .clr_ovf_i(clr_ovf_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] rxq[$];

  // inputs change just after posedge, so the negedge sees what the next edge will
  always @(negedge clk_i) if (!rst_i && valid_o && ready_i) rxq.push_back(data_o);

  typedef struct {
    logic [31:0] x, y, z;
    int          stall_idx;
    int          stall_len;
    logic [7:0]  csum;
  } vec_t;
  vec_t vt[5];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(logic [31:0] x, logic [31:0] y, logic [31:0] z);
    xn_i = x; yn_i = y; zn_i = z; sample_i = 1'b1;
    step();
    sample_i = 1'b0;
  endtask

  function automatic logic [7:0] xsum(logic [31:0] x, logic [31:0] y, logic [31:0] z);
    logic [95:0] p;
    logic [7:0]  s;
    p = {x, y, z};
    s = 8'h00;
    for (int i = 0; i < 12; i++) s = s ^ p[95-8*i -: 8];
    return s;
  endfunction

  function automatic logic [7:0] byte_at(logic [31:0] x, logic [31:0] y, logic [31:0] z,
                                         logic [7:0] cs, int idx);
    logic [95:0] p;
    p = {x, y, z};
    if (idx == 0) return 8'hA5;
    if (idx == FB - 1) return cs;
    return p[95-8*(idx-1) -: 8];
  endfunction

  task automatic check_frame(string name, logic [31:0] x, logic [31:0] y, logic [31:0] z,
                             logic [7:0] cs);
    if (rxq.size() < FB) begin
      check({name, " length"}, rxq.size(), FB);
      rxq.delete();
    end else begin
      for (int i = 0; i < FB; i++)
        check($sformatf("%s byte%0d", name, i), rxq.pop_front(), byte_at(x, y, z, cs, i));
    end
    $display("frame %s x=%08h y=%08h z=%08h csum=%02h", name, x, y, z, cs);
  endtask

  task automatic wait_idle(string name, int budget);
    for (int c = 0; c < budget && busy_o; c++) step();
    check({name, " drained"}, busy_o, 1'b0);
  endtask

  task automatic wait_bytes(int n, int budget);
    for (int c = 0; c < budget && rxq.size() < n; c++) step();
  endtask

  initial begin
    vt[0] = '{32'h00200000, 32'hFFE00000, 32'h03200000, -1, 0, 8'h1C};
    vt[1] = '{32'h00200000, 32'hFFE00000, 32'h03200000,  5, 5, 8'h1C};
    vt[2] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, -1, 0, 8'h00};
    vt[3] = '{32'h000000FF, 32'h00000000, 32'h80000001, 13, 3, 8'h7E};
    vt[4] = '{32'h01020304, 32'h00000000, 32'h00000000,  0, 2, 8'h04};

    rst_i = 1'b1; enable_i = 1'b0; sample_i = 1'b0; ready_i = 1'b1; clr_ovf_i = 1'b0;
    xn_i = '0; yn_i = '0; zn_i = '0; decim_i = '0;
    steps(3);
    check("reset data", data_o, 8'h00);
    check("reset valid", valid_o, 1'b0);
    check("reset busy", busy_o, 1'b0);
    check("reset ovf", overflow_o, 1'b0);
    rst_i = 1'b0;
    enable_i = 1'b1;
    step();

    // table-driven single frames with optional backpressure
    for (int v = 0; v < 5; v++) begin
      rxq.delete();
      ready_i = 1'b1;
      strobe(vt[v].x, vt[v].y, vt[v].z);
      check($sformatf("v%0d valid edge1", v), valid_o, 1'b0);
      step();
      check($sformatf("v%0d valid edge2", v), valid_o, 1'b0);
      step();
      check($sformatf("v%0d valid edge3", v), valid_o, 1'b1);
      check($sformatf("v%0d sync", v), data_o, 8'hA5);
      for (int c = 0; c < 100 && rxq.size() < FB; c++) begin
        if (vt[v].stall_idx >= 0 && rxq.size() == vt[v].stall_idx) begin
          ready_i = 1'b0;
          for (int k = 0; k < vt[v].stall_len; k++) begin
            step();
            check($sformatf("v%0d stall valid", v), valid_o, 1'b1);
            check($sformatf("v%0d stall data", v), data_o,
                  byte_at(vt[v].x, vt[v].y, vt[v].z, vt[v].csum, vt[v].stall_idx));
          end
          ready_i = 1'b1;
        end
        step();
      end
      check_frame($sformatf("v%0d", v), vt[v].x, vt[v].y, vt[v].z, vt[v].csum);
      step();
      check($sformatf("v%0d busy after", v), busy_o, 1'b0);
    end

    // decimation: keep 1 of 10
    rxq.delete();
    decim_i = 16'd9;
    for (int n = 0; n < 100; n++) begin
      strobe(n, ~n, 3 * n);
      step();
    end
    wait_idle("decim", 300);
    check("decim ovf", overflow_o, 1'b0);
    check("decim bytes", rxq.size(), 10 * FB);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] x;
      x = 10 * k;
      check_frame($sformatf("dec%0d", k), x, ~x, 3 * x, xsum(x, ~x, 3 * x));
    end

    // overflow with every strobe kept
    rxq.delete();
    decim_i = 16'd0;
    for (int n = 0; n < 40; n++) begin
      strobe(n, ~n, 3 * n);
      step();
    end
    check("ovf set", overflow_o, 1'b1);
    wait_idle("ovf", 1000);
    check("ovf whole frames", rxq.size() % FB, 0);
    begin
      int nfr;
      logic [31:0] prev;
      nfr = 0;
      prev = 32'hFFFFFFFF;
      while (rxq.size() >= FB) begin
        logic [31:0] x;
        x = {rxq[1], rxq[2], rxq[3], rxq[4]};
        if (nfr == 0) check("ovf first x", x, 0);
        else check($sformatf("ovf order%0d", nfr), x > prev, 1'b1);
        check_frame($sformatf("ovf%0d", nfr), x, ~x, 3 * x, xsum(x, ~x, 3 * x));
        prev = x;
        nfr++;
      end
      check("ovf frames > depth", nfr > D, 1'b1);
    end
    check("ovf still set", overflow_o, 1'b1);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    check("ovf cleared", overflow_o, 1'b0);

    // reset during payload byte 5 with two triples queued
    rxq.delete();
    xn_i = 32'h1; yn_i = 32'h2; zn_i = 32'h3; sample_i = 1'b1;
    step();
    xn_i = 32'h4; step();
    xn_i = 32'h5; step();
    sample_i = 1'b0;
    wait_bytes(5, 50);
    check("rst bytes before", rxq.size(), 5);
    rst_i = 1'b1;
    step();
    check("rst valid", valid_o, 1'b0);
    check("rst busy", busy_o, 1'b0);
    check("rst ovf", overflow_o, 1'b0);
    rst_i = 1'b0;
    rxq.delete();
    begin
      int vhigh;
      vhigh = 0;
      for (int c = 0; c < 40; c++) begin
        step();
        if (valid_o) vhigh++;
      end
      check("rst no resume", vhigh, 0);
    end
    strobe(32'h00000777, 32'h0, 32'h0);
    wait_idle("rst recover", 100);
    check_frame("rst recover", 32'h777, 32'h0, 32'h0, xsum(32'h777, 32'h0, 32'h0));

    // enable gating resets the decimation phase
    rxq.delete();
    decim_i = 16'd3;
    strobe(32'h100, 32'h0, 32'h0);
    wait_idle("en first", 100);
    check_frame("en first", 32'h100, 32'h0, 32'h0, xsum(32'h100, 32'h0, 32'h0));
    enable_i = 1'b0;
    for (int n = 0; n < 10; n++) begin
      strobe(32'hDEAD, 32'h0, 32'h0);
      step();
    end
    steps(5);
    check("en off bytes", rxq.size(), 0);
    check("en off busy", busy_o, 1'b0);
    enable_i = 1'b1;
    strobe(32'h200, 32'h0, 32'h0);
    wait_idle("en phase", 100);
    check_frame("en phase", 32'h200, 32'h0, 32'h0, xsum(32'h200, 32'h0, 32'h0));

    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    strobe(32'h300, 32'h11, 32'h22);
    wait_bytes(3, 50);
    enable_i = 1'b0;
    wait_idle("en midframe", 100);
    check_frame("en midframe", 32'h300, 32'h11, 32'h22, xsum(32'h300, 32'h11, 32'h22));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
